// File: rtl/within_pkg.sv
// Shared definitions for the within-operator stimulus generator and its downstream checker.
package within_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    POST
  } state_t;

  localparam int unsigned A_LEN_DEF = 4;
  localparam int unsigned GAP_DEF   = 2;
  localparam int unsigned B_LEN_DEF = 2;

  function automatic int unsigned win_len(input int unsigned a_len,
                                          input int unsigned gap,
                                          input int unsigned b_len);
    return a_len + gap + b_len;
  endfunction

endpackage

// File: rtl/within_stim_gen_win_shaper.sv
// Combinational decode of a/b/c/d for one window cycle; registered by the caller.
module win_shaper
  import within_pkg::*;
#(
  parameter int unsigned A_LEN = A_LEN_DEF,
  parameter int unsigned GAP   = GAP_DEF,
  parameter int unsigned B_LEN = B_LEN_DEF,
  localparam int unsigned WIN  = win_len(A_LEN, GAP, B_LEN),
  localparam int unsigned KW   = $clog2(WIN)
) (
  input  state_t         state,
  input  logic [KW-1:0]  k,
  input  logic [WIN-1:0] c_pat,
  input  logic [WIN-1:0] d_pat,
  output logic           a,
  output logic           b,
  output logic           c,
  output logic           d
);

  // Both boundaries are < WIN because B_LEN >= 1, so they fit in KW bits.
  localparam logic [KW-1:0] A_END   = KW'(A_LEN);
  localparam logic [KW-1:0] B_START = KW'(A_LEN + GAP);

  always_comb begin
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    d = 1'b0;
    if (state == RUN) begin
      a = (k < A_END);
      b = (k >= B_START);
      c = c_pat[k];
      d = d_pat[k];
    end
  end

endmodule

// File: rtl/within_stim_gen.sv
// Framed a/b reference-window generator with pattern-driven c/d events and repeat count.
module within_stim_gen
  import within_pkg::*;
#(
  parameter int unsigned A_LEN = A_LEN_DEF,
  parameter int unsigned GAP   = GAP_DEF,
  parameter int unsigned B_LEN = B_LEN_DEF,
  parameter int unsigned REP_W = 4,
  localparam int unsigned WIN  = win_len(A_LEN, GAP, B_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WIN-1:0]          c_pat,
  input  logic [WIN-1:0]          d_pat,
  input  logic [REP_W-1:0]        rep,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    d,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(WIN)-1:0]  win_idx,
  output logic [REP_W-1:0]        rep_idx
);

  localparam int unsigned   KW     = $clog2(WIN);
  localparam logic [KW-1:0] K_LAST = KW'(WIN - 1);

  state_t           state, nxt_state;
  logic [KW-1:0]    k, nxt_k;
  logic [REP_W-1:0] rep_lat, nxt_rep_lat;
  logic [REP_W-1:0] nxt_rep_idx;
  logic [WIN-1:0]   c_lat, d_lat, nxt_c_lat, nxt_d_lat;
  logic             nxt_done;
  logic             sh_a, sh_b, sh_c, sh_d;

  always_comb begin
    nxt_state   = state;
    nxt_k       = k;
    nxt_rep_idx = rep_idx;
    nxt_rep_lat = rep_lat;
    nxt_c_lat   = c_lat;
    nxt_d_lat   = d_lat;
    nxt_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          nxt_state   = RUN;
          nxt_k       = '0;
          nxt_rep_idx = '0;
          nxt_rep_lat = rep;
          nxt_c_lat   = c_pat;
          nxt_d_lat   = d_pat;
        end
      end
      RUN: begin
        if (abort) begin
          nxt_state   = IDLE;
          nxt_k       = '0;
          nxt_rep_idx = '0;
        end else if (k == K_LAST) begin
          nxt_state = POST;
          nxt_k     = '0;
        end else begin
          nxt_k = k + 1'b1;
        end
      end
      POST: begin
        if (abort) begin
          nxt_state   = IDLE;
          nxt_rep_idx = '0;
        end else if (rep_idx < rep_lat) begin
          nxt_state   = RUN;
          nxt_k       = '0;
          nxt_rep_idx = rep_idx + 1'b1;
        end else begin
          nxt_state   = IDLE;
          nxt_rep_idx = '0;
          nxt_done    = 1'b1;
        end
      end
      default: begin
        nxt_state   = IDLE;
        nxt_k       = '0;
        nxt_rep_idx = '0;
      end
    endcase
  end

  // Decoding the next state lets a rise in the very first cycle after the start edge.
  win_shaper #(
    .A_LEN (A_LEN),
    .GAP   (GAP),
    .B_LEN (B_LEN)
  ) u_shaper (
    .state (nxt_state),
    .k     (nxt_k),
    .c_pat (nxt_c_lat),
    .d_pat (nxt_d_lat),
    .a     (sh_a),
    .b     (sh_b),
    .c     (sh_c),
    .d     (sh_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      rep_idx <= '0;
      rep_lat <= '0;
      c_lat   <= '0;
      d_lat   <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      c       <= 1'b0;
      d       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt_state;
      k       <= nxt_k;
      rep_idx <= nxt_rep_idx;
      rep_lat <= nxt_rep_lat;
      c_lat   <= nxt_c_lat;
      d_lat   <= nxt_d_lat;
      a       <= sh_a;
      b       <= sh_b;
      c       <= sh_c;
      d       <= sh_d;
      busy    <= (nxt_state != IDLE);
      done    <= nxt_done;
    end
  end

  // k is held at zero outside RUN, so it doubles as the window index output.
  assign win_idx = k;

endmodule

// File: tb/tb_within_stim_gen.sv
// Self-checking bench for within_stim_gen: scenario table, corner sequences and random bursts.
module tb_within_stim_gen;

  localparam int A   = 4;
  localparam int G   = 2;
  localparam int B   = 2;
  localparam int WIN = A + G + B;
  localparam int PER = WIN + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] c_pat = '0;
  logic [7:0] d_pat = '0;
  logic [3:0] rep = '0;
  logic       a, b, c, d, busy, done;
  logic [2:0] win_idx;
  logic [3:0] rep_idx;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       a, b, c, d, busy, done;
    logic [2:0] win_idx;
    logic [3:0] rep_idx;
  } obs_t;

  typedef struct {
    logic [7:0] cp;
    logic [7:0] dp;
    int         rp;
    int         done_edge;
    int         ccnt;
    int         dcnt;
  } vec_t;

  within_stim_gen #(
    .A_LEN (A),
    .GAP   (G),
    .B_LEN (B),
    .REP_W (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .c_pat   (c_pat),
    .d_pat   (d_pat),
    .rep     (rep),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .busy    (busy),
    .done    (done),
    .win_idx (win_idx),
    .rep_idx (rep_idx)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.a = a; o.b = b; o.c = c; o.d = d;
    o.busy = busy; o.done = done;
    o.win_idx = win_idx; o.rep_idx = rep_idx;
    return o;
  endfunction

  // Expected outputs in cycle t after the start edge; cut = first cycle forced idle (0 = none).
  function automatic obs_t model(int t, logic [7:0] cp, logic [7:0] dp, int rp, int cut);
    obs_t o = '0;
    int total = (rp + 1) * PER;
    int p, w;
    if (cut != 0 && t >= cut) return o;
    if (t > total + 1) return o;
    if (t == total + 1) begin
      o.done = 1'b1;
      return o;
    end
    p = (t - 1) % PER;
    w = (t - 1) / PER;
    o.busy = 1'b1;
    o.rep_idx = w[3:0];
    if (p < WIN) begin
      o.a = (p < A);
      o.b = (p >= A + G);
      o.c = cp[p];
      o.d = dp[p];
      o.win_idx = p[2:0];
    end
    return o;
  endfunction

  task automatic check_obs(string name, int t, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got a%b b%b c%b d%b busy%b done%b wi%0d ri%0d required a%b b%b c%b d%b busy%b done%b wi%0d ri%0d",
               name, t, got.a, got.b, got.c, got.d, got.busy, got.done, got.win_idx, got.rep_idx,
               exp.a, exp.b, exp.c, exp.d, exp.busy, exp.done, exp.win_idx, exp.rep_idx);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // One burst; checks every cycle. noise scrambles inputs and pulses start while busy.
  task automatic run_burst(input string name, input logic [7:0] cp, input logic [7:0] dp,
                           input int rp, input int abort_t, input int rst_t, input bit noise,
                           output int done_edge, output int ccnt, output int dcnt);
    int   cut = 0;
    int   total = (rp + 1) * PER;
    obs_t exp, got;
    done_edge = -1; ccnt = 0; dcnt = 0;
    c_pat = cp; d_pat = dp; rep = rp[3:0]; start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= total + 2; t++) begin
      exp = model(t, cp, dp, rp, cut);
      got = sample();
      check_obs(name, t, got, exp);
      if (got.done) done_edge = t - 1;
      if (got.c) ccnt++;
      if (got.d) dcnt++;
      abort = 1'b0; rst = 1'b0; start = 1'b0;
      if (noise && exp.busy) begin
        c_pat = 8'($urandom); d_pat = 8'($urandom); rep = 4'($urandom);
        start = 1'($urandom);
      end
      if (t == abort_t) begin abort = 1'b1; cut = t + 1; end
      if (t == rst_t) begin rst = 1'b1; cut = t + 1; end
      @(posedge clk); #1;
    end
    abort = 1'b0; rst = 1'b0; start = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    int de, cc, dc;
    obs_t zero = '0;

    vecs[0] = '{8'b0000_1010, 8'b0101_0000, 0, 9, 2, 2};
    vecs[1] = '{8'b0000_1010, 8'b1000_0000, 0, 9, 2, 1};
    vecs[2] = '{8'b0000_1010, 8'b0101_0000, 2, 27, 6, 6};
    vecs[3] = '{8'hFF, 8'h00, 1, 18, 16, 0};

    // Reset with start held high: reset must win.
    start = 1'b1; c_pat = 8'hFF; d_pat = 8'hFF; rep = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset", 0, sample(), zero);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_obs("idle_after_reset", 0, sample(), zero);

    for (int i = 0; i < 4; i++) begin
      run_burst($sformatf("vec%0d", i), vecs[i].cp, vecs[i].dp, vecs[i].rp, 0, 0, i[0],
                de, cc, dc);
      check_int($sformatf("vec%0d_done_edge", i), de, vecs[i].done_edge);
      check_int($sformatf("vec%0d_c_count", i), cc, vecs[i].ccnt);
      check_int($sformatf("vec%0d_d_count", i), dc, vecs[i].dcnt);
    end

    // Abort at k=5 of window 0, then a normal burst.
    run_burst("abort_k5", 8'b0000_1010, 8'b0101_0000, 2, 6, 0, 1'b0, de, cc, dc);
    check_int("abort_no_done", de, -1);
    run_burst("after_abort", 8'b0000_1010, 8'b0101_0000, 0, 0, 0, 1'b0, de, cc, dc);
    check_int("after_abort_done_edge", de, 9);

    // start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_obs("start_abort_idle", i, sample(), zero);
      @(posedge clk); #1;
    end

    // Reset at k=2, then scenario 1 must repeat exactly.
    run_burst("rst_k2", 8'b0000_1010, 8'b0101_0000, 0, 0, 3, 1'b0, de, cc, dc);
    check_int("rst_no_done", de, -1);
    run_burst("after_rst", vecs[0].cp, vecs[0].dp, vecs[0].rp, 0, 0, 1'b0, de, cc, dc);
    check_int("after_rst_done_edge", de, vecs[0].done_edge);
    check_int("after_rst_c_count", cc, vecs[0].ccnt);
    check_int("after_rst_d_count", dc, vecs[0].dcnt);

    for (int n = 0; n < 25; n++) begin
      logic [7:0] rcp, rdp;
      int rrp, rab;
      rcp = 8'($urandom);
      rdp = 8'($urandom);
      rrp = $urandom_range(0, 3);
      rab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (rrp + 1) * PER) : 0;
      run_burst($sformatf("rand%0d", n), rcp, rdp, rrp, rab, 0, 1'b1, de, cc, dc);
      check_int($sformatf("rand%0d_done_edge", n), de, (rab != 0) ? -1 : (rrp + 1) * PER);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/within_stim_gen.md
Name: within_stim_gen

Overview:
Synthesizable stimulus generator that sits directly upstream of the within-operator check stage. It drives a, b, c and d to form one or more framed reference windows: a[*A_LEN] ##(GAP+1) b[*B_LEN]. During each window, c and d pulse on cycles chosen by programmable bit patterns. The downstream stage is the property $rose(a) |-> (c-sequence) within (a/b reference window), which the generator must be able to satisfy or violate on demand.

Parameters:
A_LEN, 4, cycles a is held high per window (>=1)
GAP, 2, cycles between a falling and b rising; a and b both low during the gap (>=0)
B_LEN, 2, cycles b is held high per window (>=1)
WIN, A_LEN+GAP+B_LEN (derived localparam), window length in cycles
REP_W, 4, width of repeat-count input

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a burst; sampled only in IDLE
abort  in  1  synchronous abort of an active burst
c_pat  in  WIN  bit i drives c during window cycle i; latched on accepted start
d_pat  in  WIN  bit i drives d during window cycle i; latched on accepted start
rep  in  REP_W  number of windows minus 1; latched on accepted start
a  out  1  reference-window head signal
b  out  1  reference-window tail signal
c  out  1  test-sequence event 1
d  out  1  test-sequence event 2
busy  out  1  high from the cycle after an accepted start until the return to IDLE
done  out  1  one-cycle pulse when a burst completes normally
win_idx  out  $clog2(WIN)  current window cycle index; 0 when not in RUN
rep_idx  out  REP_W  index of the window in progress; 0 in IDLE

Behaviour:
- All outputs are registered. On rst=1 at an edge: state=IDLE, all outputs 0, latched patterns 0. rst overrides start and abort.
- FSM states: IDLE, RUN, POST.
- IDLE: a, b, c, d, busy = 0. When start=1 and abort=0: latch c_pat, d_pat and rep, go to RUN with k=0. Start is ignored in all other states.
- RUN, cycle k = 0..WIN-1 (k = cycles since entering RUN):
  - a = (k < A_LEN)
  - b = (k >= A_LEN+GAP)
  - c = c_pat[k], d = d_pat[k]
  - win_idx = k
  - Latency: a is high in the first cycle after the start edge.
  - When k = WIN-1, go to POST.
- POST: exactly 1 cycle with a, b, c, d = 0, busy=1. This guarantees $rose(a) between back-to-back windows.
  - If rep_idx < latched rep: rep_idx+1, go to RUN with k=0.
  - Otherwise go to IDLE and assert done=1 for exactly 1 cycle, coinciding with the first IDLE cycle.
- Window period is WIN+1 cycles. A burst lasts (rep+1)*(WIN+1) cycles from the start edge to done.
- abort=1 in RUN or POST: at the next edge go to IDLE with all outputs 0 and no done pulse. abort in IDLE has no effect; abort wins over a simultaneous start.
- c_pat, d_pat and rep may change while busy=1 with no effect until the next accepted start.
- Counter k saturates logic at WIN-1. No wrap beyond the window. rep_idx never exceeds the latched rep.

Decomposition:
- Shared package within_pkg:
  - state enum {IDLE, RUN, POST}
  - default A_LEN, GAP and B_LEN constants
  - function win_len(A, G, B) returning A+G+B
  - the downstream checker imports the same package
- One natural sub-module, win_shaper: combinational a/b/c/d decode from (k, state, latched patterns), registered in the top.

Test Plan:
1. Defaults; start with c_pat=8'b0000_1010, d_pat=8'b0101_0000, rep=0 -> a high k=0..3, b high k=6..7, c at k=1,3, d at k=4,6; done 9 cycles after the start edge; downstream assertion passes.
2. Same as 1 but d_pat=8'b1000_0000 -> second d cannot occur inside the window; downstream assertion fails; generator timing identical to 1.
3. rep=2 -> three windows, each a rise preceded by exactly 1 low cycle; rep_idx 0,1,2; single done at cycle 27.
4. abort asserted at k=5 of window 0 -> all outputs 0 at the next edge, busy=0, no done; a later start works normally.
5. start pulsed while busy, and start+abort together in IDLE -> both ignored, no state change.
6. rst asserted mid-RUN (k=2) -> next edge: all outputs 0, IDLE; a fresh start reproduces scenario 1 exactly.
